// File: rtl/param_data_mem.sv
// param_data_mem: word memory with a fixed access latency and a request/ready FSM.
// Define BYTE_EN_EN to add the be port and byte-masked writes.
module param_data_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MR,
    input  logic              MW,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wd,
`ifdef BYTE_EN_EN
    input  logic [DATA_W/8-1:0] be,
`endif
    output logic [DATA_W-1:0] rd,
    output logic              ready,
    output logic              err,
    output logic [2:0]        state
);
    localparam int NB = DATA_W / 8;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR_WAIT = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              mem_we;
`ifdef BYTE_EN_EN
    logic [NB-1:0]     be_q, be_d;
`endif

    logic [DATA_W-1:0] mem_array [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
`ifdef BYTE_EN_EN
        be_d    = be_q;
`endif
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MR || MW) begin
                    if ((MR && MW) || addr >= 32'(DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        state_d = MR ? RD_WAIT : WR_WAIT;
                        cnt_d   = CW'(LAT - 1);
                        addr_d  = addr[AW-1:0];
                        wd_d    = wd;
`ifdef BYTE_EN_EN
                        be_d    = be;
`endif
                    end
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (state_q == RD_WAIT) rd_d = mem_array[addr_q];
                    // gating with rst keeps an access aborted by reset from landing
                    else mem_we = rst;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
`ifdef BYTE_EN_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
`ifdef BYTE_EN_EN
            be_q    <= be_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
`ifdef BYTE_EN_EN
            for (int i = 0; i < NB; i++)
                if (be_q[i]) mem_array[addr_q][8*i +: 8] <= wd_q[8*i +: 8];
`else
            mem_array[addr_q] <= wd_q;
`endif
        end
    end

    assign rd    = rd_q;
    assign ready = (state_q == DONE);
    assign err   = (state_q == ERR);
    assign state = state_q;
endmodule

// File: tb/tb_param_data_mem.sv
// tb_param_data_mem: directed plus random accesses on a LAT=4 and a LAT=1 instance,
// checked against an array model of memory and read data.
module tb_param_data_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        mr0, mw0, mr1, mw1;
    logic [31:0] a0, a1, w0, w1;
    logic [3:0]  be0, be1;
    logic [31:0] rd0, rd1;
    logic        rdy0, rdy1, er0, er1;
    logic [2:0]  st0, st1;

    logic [31:0] m0 [1024];
    logic [31:0] m1 [16];
    logic [31:0] r0, r1;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    param_data_mem u0 (
        .clk(clk), .rst(rst), .MR(mr0), .MW(mw0), .addr(a0), .wd(w0),
`ifdef BYTE_EN_EN
        .be(be0),
`endif
        .rd(rd0), .ready(rdy0), .err(er0), .state(st0)
    );

    param_data_mem #(.DATA_W(32), .DEPTH(16), .LAT(1)) u1 (
        .clk(clk), .rst(rst), .MR(mr1), .MW(mw1), .addr(a1), .wd(w1),
`ifdef BYTE_EN_EN
        .be(be1),
`endif
        .rd(rd1), .ready(rdy1), .err(er1), .state(st1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic mr, input logic mw,
                         input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        if (sel) begin
            mr1 = mr; mw1 = mw; a1 = a; w1 = w; be1 = be;
        end else begin
            mr0 = mr; mw0 = mw; a0 = a; w0 = w; be0 = be;
        end
    endtask

    task automatic junk(input bit sel);
        drive(sel, 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
        return (old & ~mask) | (w & mask);
    endfunction

    // One complete access from IDLE: latency, handshake and data taken from the model.
    task automatic run(input bit sel, input logic mr, input logic mw,
                       input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        int          depth = sel ? 16 : 1024;
        int          lat = sel ? 1 : 4;
        logic        bad = (mr && mw) || (a >= 32'(depth));
        logic [3:0]  ebe = be;
`ifndef BYTE_EN_EN
        ebe = 4'hF;
`endif
        drive(sel, mr, mw, a, w, be);
        @(posedge clk); #1;
        junk(sel);
        if (bad) begin
            check("err_state", sel ? st1 : st0, 32'd4);
            check("err_flag", sel ? er1 : er0, 32'd1);
            check("err_ready", sel ? rdy1 : rdy0, 32'd0);
            check("err_rd", sel ? rd1 : rd0, sel ? r1 : r0);
        end else begin
            for (int k = 0; k < lat; k++) begin
                check("wait_state", sel ? st1 : st0, mr ? 32'd1 : 32'd2);
                check("wait_ready", sel ? rdy1 : rdy0, 32'd0);
                @(posedge clk); #1;
            end
            if (mr) begin
                if (sel) r1 = m1[a[3:0]]; else r0 = m0[a[9:0]];
            end else begin
                if (sel) m1[a[3:0]] = merge(m1[a[3:0]], w, ebe);
                else m0[a[9:0]] = merge(m0[a[9:0]], w, ebe);
            end
            check("done_state", sel ? st1 : st0, 32'd3);
            check("done_ready", sel ? rdy1 : rdy0, 32'd1);
            check("done_err", sel ? er1 : er0, 32'd0);
            check("done_rd", sel ? rd1 : rd0, sel ? r1 : r0);
        end
        @(posedge clk); #1;
        check("back_idle", sel ? st1 : st0, 32'd0);
        check("idle_flags", sel ? {rdy1, er1} : {rdy0, er0}, 32'd0);
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b0;
        r0 = '0;
        r1 = '0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            u0.mem_array[i] = v;
            m0[i] = v;
        end
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            u1.mem_array[i] = v;
            m1[i] = v;
        end
        u0.mem_array[5] = 32'h0000_00AB; m0[5] = 32'h0000_00AB;
        u0.mem_array[3] = 32'h1122_3344; m0[3] = 32'h1122_3344;
        #1;
        check("rst_state", st0, 32'd0);
        check("rst_rd", rd0, 32'd0);
        check("rst_flags", {rdy0, er0}, 32'd0);
        check("rst_state1", st1, 32'd0);
        check("rst_rd1", rd1, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // preloaded read, then write/read-back
        run(0, 1'b1, 1'b0, 32'd5, 32'd0, 4'd0);
        check("read5", rd0, 32'h0000_00AB);
        run(0, 1'b0, 1'b1, 32'd12, 32'd85, 4'hF);
        run(0, 1'b1, 1'b0, 32'd12, 32'd0, 4'd0);
        check("read12", rd0, 32'd85);

        // rejected requests and the address boundary
        run(0, 1'b1, 1'b1, 32'd5, 32'hFFFF_FFFF, 4'hF);
        run(0, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd0);
        run(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 4'hF);
        run(0, 1'b1, 1'b0, 32'd1023, 32'd0, 4'd0);
        run(0, 1'b1, 1'b0, 32'd5, 32'd0, 4'd0);
        check("read5_again", rd0, 32'h0000_00AB);

        // reset during a write: immediate clear, memory untouched
        drive(0, 1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF, 4'hF);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_state", st0, 32'd0);
        check("abort_rd", rd0, 32'd0);
        check("abort_flags", {rdy0, er0}, 32'd0);
        r0 = '0;
        r1 = '0;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        run(0, 1'b1, 1'b0, 32'd7, 32'd0, 4'd0);
        check("read7_kept", rd0 == 32'hDEAD_BEEF, 32'd0);

`ifdef BYTE_EN_EN
        run(0, 1'b0, 1'b1, 32'd3, 32'hAABB_CCDD, 4'b0010);
        run(0, 1'b1, 1'b0, 32'd3, 32'd0, 4'd0);
        check("byte_en", rd0, 32'h1122_CC44);
        run(0, 1'b0, 1'b1, 32'd3, 32'hFFFF_FFFF, 4'b0000);
        run(0, 1'b1, 1'b0, 32'd3, 32'd0, 4'd0);
        check("be_zero", rd0, 32'h1122_CC44);
`endif

        // LAT=1 instance: inputs are scrambled during RD_WAIT by run()
        run(1, 1'b1, 1'b0, 32'd2, 32'd0, 4'd0);
        run(1, 1'b0, 1'b1, 32'd9, 32'hCAFE_F00D, 4'hF);
        run(1, 1'b1, 1'b0, 32'd9, 32'd0, 4'd0);
        run(1, 1'b1, 1'b0, 32'd16, 32'd0, 4'd0);
        run(1, 1'b1, 1'b0, 32'd15, 32'd0, 4'd0);

        for (int n = 0; n < 60; n++) begin
            bit sel = 1'($urandom);
            int depth = sel ? 16 : 1024;
            int kind = $urandom_range(0, 5);
            logic [31:0] a = 32'($urandom_range(0, depth));
            run(sel, kind != 1, kind == 1 || kind == 2, a, $urandom, 4'($urandom));
        end
        for (int i = 0; i < 16; i++) run(1, 1'b1, 1'b0, 32'(i), 32'd0, 4'd0);
        for (int i = 0; i < 16; i++) run(0, 1'b1, 1'b0, 32'(i), 32'd0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
